// File: rtl/nfet_pkg.sv
// Shared types and parameter defaults for the n-channel FET switch model.
package nfet_pkg;

  typedef enum logic [1:0] {
    FM_NONE   = 2'b00,
    FM_OPEN   = 2'b01,
    FM_CLOSED = 2'b10,
    FM_RSVD   = 2'b11
  } fault_mode_t;

  localparam int TON_CYC_DEF  = 0;
  localparam int TOFF_CYC_DEF = 0;
  localparam int CNT_W_DEF    = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nfet_delay_filter.sv
// On/off debounce for the gate: the channel flips only after the gate has
// held the opposite level for TON_CYC / TOFF_CYC consecutive clocks.
module nfet_delay_filter
  import nfet_pkg::*;
#(
  parameter int TON_CYC  = TON_CYC_DEF,
  parameter int TOFF_CYC = TOFF_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic gate,
  output logic on_q,
  output logic on_nxt
);

  localparam int CW = max_int($clog2(max_int(TON_CYC, TOFF_CYC) + 1), 1);
  localparam logic [CW-1:0] TON_L  = CW'(TON_CYC);
  localparam logic [CW-1:0] TOFF_L = CW'(TOFF_CYC);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] target;

  // cnt never exceeds target-1, so cnt_inc cannot wrap
  always_comb begin
    cnt_inc = cnt + CW'(1);
    target  = on_q ? TOFF_L : TON_L;
    on_nxt  = on_q;
    cnt_nxt = '0;
    if (gate != on_q) begin
      if (cnt_inc >= target) on_nxt = gate;
      else                   cnt_nxt = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      on_q <= 1'b0;
      cnt  <= '0;
    end else begin
      on_q <= on_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/nfet_switch.sv
// Open-drain n-channel FET pull-down: drives drn low or releases it, never high.
// Optional fault_mode port is enabled by defining NFET_FAULT_INJ_EN.
module nfet_switch
  import nfet_pkg::*;
#(
  parameter int TON_CYC  = TON_CYC_DEF,
  parameter int TOFF_CYC = TOFF_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             src,
  input  logic             gate,
  inout  wire              drn,
  input  logic             clk,
  input  logic             rst,
  output logic             on,
  output logic [CNT_W-1:0] sw_count
`ifdef NFET_FAULT_INJ_EN
  ,
  input  logic [1:0]       fault_mode
`endif
);

  logic on_base;
  logic on_base_nxt;
  logic on_eff;
  logic on_smp;
  logic on_prev;

  generate
    if (TON_CYC == 0 && TOFF_CYC == 0) begin : g_comb
      assign on_base     = gate;
      assign on_base_nxt = gate;
    end else begin : g_dly
      nfet_delay_filter #(
        .TON_CYC (TON_CYC),
        .TOFF_CYC(TOFF_CYC)
      ) u_filt (
        .clk   (clk),
        .rst   (rst),
        .gate  (gate),
        .on_q  (on_base),
        .on_nxt(on_base_nxt)
      );
    end
  endgenerate

`ifdef NFET_FAULT_INJ_EN
  fault_mode_t fm;

  function automatic logic apply_fault(input fault_mode_t m, input logic v);
    case (m)
      FM_OPEN:   return 1'b0;
      FM_CLOSED: return 1'b1;
      default:   return v;
    endcase
  endfunction

  assign fm     = fault_mode_t'(fault_mode);
  assign on_eff = apply_fault(fm, on_base);
  assign on_smp = apply_fault(fm, on_base_nxt);
`else
  assign on_eff = on_base;
  assign on_smp = on_base_nxt;
`endif

  assign on  = on_eff;
  // X/Z on src must read as not-low, hence the case-equality test
  assign drn = (on_eff && (src === 1'b0)) ? 1'b0 : 1'bz;

  // Count rises of the channel state that will be visible after this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      on_prev  <= 1'b0;
      sw_count <= '0;
    end else begin
      on_prev <= on_smp;
      if (on_smp && !on_prev && (sw_count != '1))
        sw_count <= sw_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_nfet_switch.sv
// Self-checking bench for nfet_switch: directed cases plus randomized gate/src/rst
// compared against a sample-history reference model; drains are pulled up so release reads 1.
module tb_nfet_switch;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // combinational default-parameter switch
  logic        c_src = 1'b1, c_gate = 1'b0, c_on;
  logic [15:0] c_cnt;
  wire         c_drn;
  pullup (c_drn);

  // two-stage chain
  logic        a_gate = 1'b0, rd = 1'b0, a_on, b_on;
  logic [15:0] a_cnt, b_cnt;
  wire         t1, bus;
  pullup (t1);
  pullup (bus);

  // delayed switch
  logic        d_src = 1'b1, d_gate = 1'b0, d_on;
  logic [15:0] d_cnt;
  wire         d_drn;
  pullup (d_drn);

  // narrow counter
  logic        s_src = 1'b0, s_gate = 1'b0, s_on;
  logic [3:0]  s_cnt;
  wire         s_drn;
  pullup (s_drn);

`ifdef NFET_FAULT_INJ_EN
  logic [1:0] c_fm = 2'b00, a_fm = 2'b00, b_fm = 2'b00, d_fm = 2'b00, s_fm = 2'b00;
`endif

  nfet_switch u_comb (.src(c_src), .gate(c_gate), .drn(c_drn), .clk(clk), .rst(rst),
                      .on(c_on), .sw_count(c_cnt)
`ifdef NFET_FAULT_INJ_EN
                      , .fault_mode(c_fm)
`endif
                      );
  nfet_switch u_a (.src(1'b0), .gate(a_gate), .drn(t1), .clk(clk), .rst(rst),
                   .on(a_on), .sw_count(a_cnt)
`ifdef NFET_FAULT_INJ_EN
                   , .fault_mode(a_fm)
`endif
                   );
  nfet_switch u_b (.src(t1), .gate(rd), .drn(bus), .clk(clk), .rst(rst),
                   .on(b_on), .sw_count(b_cnt)
`ifdef NFET_FAULT_INJ_EN
                   , .fault_mode(b_fm)
`endif
                   );
  nfet_switch #(.TON_CYC(3), .TOFF_CYC(2)) u_dly (
    .src(d_src), .gate(d_gate), .drn(d_drn), .clk(clk), .rst(rst),
    .on(d_on), .sw_count(d_cnt)
`ifdef NFET_FAULT_INJ_EN
    , .fault_mode(d_fm)
`endif
  );
  nfet_switch #(.CNT_W(4)) u_sat (
    .src(s_src), .gate(s_gate), .drn(s_drn), .clk(clk), .rst(rst),
    .on(s_on), .sw_count(s_cnt)
`ifdef NFET_FAULT_INJ_EN
    , .fault_mode(s_fm)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: channel state derived from the history of sampled gate values
  bit m_hist[$];
  bit m_d_on = 0, m_d_prev = 0, m_c_prev = 0, m_s_prev = 0;
  int m_d_cnt = 0, m_c_cnt = 0, m_s_cnt = 0;

  function automatic bit last_all(input int n, input bit v);
    if (m_hist.size() < n) return 1'b0;
    for (int i = 0; i < n; i++)
      if (m_hist[m_hist.size() - 1 - i] != v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int sat_inc(input int v, input int max_v);
    return (v + 1 > max_v) ? max_v : v + 1;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_hist.delete();
      m_d_on = 0; m_d_prev = 0; m_d_cnt = 0;
      m_c_prev = 0; m_c_cnt = 0;
      m_s_prev = 0; m_s_cnt = 0;
    end else begin
      m_hist.push_back(d_gate);
      if (!m_d_on && last_all(3, 1'b1))     m_d_on = 1;
      else if (m_d_on && last_all(2, 1'b0)) m_d_on = 0;
      if (m_d_on && !m_d_prev) m_d_cnt = sat_inc(m_d_cnt, 65535);
      m_d_prev = m_d_on;
      if (c_gate && !m_c_prev) m_c_cnt = sat_inc(m_c_cnt, 65535);
      m_c_prev = c_gate;
      if (s_gate && !m_s_prev) m_s_cnt = sat_inc(m_s_cnt, 15);
      m_s_prev = s_gate;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic check_all(input string pfx);
    check_val({pfx, "_c_on"},  c_on,  c_gate);
    check_val({pfx, "_c_drn"}, c_drn, (c_gate && !c_src) ? 1'b0 : 1'b1);
    check_val({pfx, "_c_cnt"}, c_cnt, m_c_cnt);
    check_val({pfx, "_d_on"},  d_on,  m_d_on);
    check_val({pfx, "_d_drn"}, d_drn, (m_d_on && !d_src) ? 1'b0 : 1'b1);
    check_val({pfx, "_d_cnt"}, d_cnt, m_d_cnt);
    check_val({pfx, "_s_cnt"}, s_cnt, m_s_cnt);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    check_all("reset");
    check_val("reset_d_on_zero", d_on, 0);
    rst = 1'b0;

    // pure switch behaviour
    c_src = 1'b0; c_gate = 1'b0; #1;
    check_val("t1_gate0_released", c_drn, 1'b1);
    c_gate = 1'b1; #1;
    check_val("t1_gate1_pulls_low", c_drn, 1'b0);
    c_src = 1'b1; #1;
    check_val("t1_src1_released", c_drn, 1'b1);

    // chain: bus only pulled low when both stages conduct
    a_gate = 1'b0; rd = 1'b1; #1;
    check_val("t2_chain_a_off", bus, 1'b1);
    a_gate = 1'b1; #1;
    check_val("t2_chain_t1", t1, 1'b0);
    check_val("t2_chain_both_on", bus, 1'b0);

    // delayed switch: short pulse ignored, full-length pulse turns on
    d_src = 1'b0; d_gate = 1'b1;
    tick(); tick();
    d_gate = 1'b0;
    tick();
    check_val("t3_short_drn", d_drn, 1'b1);
    check_val("t3_short_cnt", d_cnt, 0);
    d_gate = 1'b1;
    tick(); tick();
    check_val("t3_before_3rd_drn", d_drn, 1'b1);
    tick();
    check_val("t3_on_drn", d_drn, 1'b0);
    check_val("t3_on_cnt", d_cnt, 1);
    d_gate = 1'b0;
    tick();
    check_val("t3_off1_drn", d_drn, 1'b0);
    tick();
    check_val("t3_off2_drn", d_drn, 1'b1);
    check_all("t3");

    // reset while conducting
    d_gate = 1'b1;
    tick(); tick(); tick();
    check_val("t4_pre_on", d_on, 1'b1);
    rst = 1'b1;
    tick();
    check_val("t4_rst_on", d_on, 1'b0);
    check_val("t4_rst_drn", d_drn, 1'b1);
    check_val("t4_rst_cnt", d_cnt, 0);
    rst = 1'b0;
    d_gate = 1'b0;
    tick();

    // saturation of narrow counter
    for (int i = 0; i < 20; i++) begin
      s_gate = 1'b1; tick();
      s_gate = 1'b0; tick();
    end
    check_val("t5_sat_cnt", s_cnt, 15);
    check_all("t5");

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      c_gate = $urandom_range(0, 1);
      c_src  = $urandom_range(0, 1);
      s_gate = $urandom_range(0, 1);
      if ($urandom_range(0, 99) < 30) d_gate = ~d_gate;
      d_src  = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      tick();
      check_all("rnd");
      d_src = ~d_src; #1;
      check_val("rnd_d_drn_src", d_drn, (m_d_on && !d_src) ? 1'b0 : 1'b1);
    end
    rst = 1'b0;

`ifdef NFET_FAULT_INJ_EN
    c_gate = 1'b1; c_src = 1'b0;
    c_fm = 2'b01; #1;
    check_val("t6_open_drn", c_drn, 1'b1);
    check_val("t6_open_on", c_on, 1'b0);
    c_fm = 2'b10; c_gate = 1'b0; #1;
    check_val("t6_closed_drn", c_drn, 1'b0);
    c_fm = 2'b00; #1;
    check_val("t6_none_gate0", c_drn, 1'b1);
    c_gate = 1'b1; #1;
    check_val("t6_none_gate1", c_drn, 1'b0);
    c_fm = 2'b11; c_gate = 1'b0; #1;
    check_val("t6_rsvd_gate0", c_drn, 1'b1);
    c_fm = 2'b00;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
